// File: rtl/game_pkg.sv
// Shared game constants and state encodings used by the ship controller, map ROM and renderer.
// No logic; no latency; no flow control.
package game_pkg;

    localparam int TRACK_LEN_DEF = 160;
    localparam int LANES_DEF     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_CRASH  = 2'b10,
        ST_FINISH = 2'b11
    } game_state_e;

endpackage

// File: rtl/ship_motion_ctrl_if.sv
// Bundle between the tick generator / buttons / map ROM and the ship controller.
// slave = controller side; master = environment side.
interface ship_motion_ctrl_if
    import game_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int XW    = 8,
    parameter int YW    = 2
);
    logic             forward_tick;
    logic             start_btn;
    logic             up_btn;
    logic             down_btn;
    logic [LANES-1:0] obstacle_col;
    logic [XW-1:0]    ship_x;
    logic [YW-1:0]    ship_y;
    logic [1:0]       game_state;
    logic             first_start;
    logic             crash_pulse;
    logic             finish_pulse;

    modport master (
        output forward_tick, start_btn, up_btn, down_btn, obstacle_col,
        input  ship_x, ship_y, game_state, first_start, crash_pulse, finish_pulse
    );

    modport slave (
        input  forward_tick, start_btn, up_btn, down_btn, obstacle_col,
        output ship_x, ship_y, game_state, first_start, crash_pulse, finish_pulse
    );
endinterface

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level; rise is combinational in the press cycle.
// Latency 0 cycles for rise; no backpressure.
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);
    logic prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) prev <= 1'b0;
        else        prev <= level;
    end

    assign rise = level & ~prev;
endmodule

// File: rtl/ship_motion_ctrl.sv
// Ship position, lane changes, collision detection and game-state sequencing.
// Latency 1 cycle from tick/button rise to outputs; no backpressure, ticks are never stalled.
module ship_motion_ctrl
    import game_pkg::*;
#(
    parameter int TRACK_LEN  = TRACK_LEN_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int XW         = 8,
    parameter int YW         = 2,
    parameter int START_LANE = 1,
    parameter int HOLD_TICKS = 50
) (
    input  logic              clock,
    input  logic              reset,
    ship_motion_ctrl_if.slave bus
);
    localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;

    logic start_rise, up_rise, down_rise;

    btn_edge u_start (.clock(clock), .reset(reset), .level(bus.start_btn), .rise(start_rise));
    btn_edge u_up    (.clock(clock), .reset(reset), .level(bus.up_btn),    .rise(up_rise));
    btn_edge u_down  (.clock(clock), .reset(reset), .level(bus.down_btn),  .rise(down_rise));

    game_state_e    state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d, y_step;
    logic [HW-1:0]  hold_q, hold_d;
    logic           crash_q, crash_d;
    logic           finish_q, finish_d;
    logic           fs_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            x_q      <= '0;
            y_q      <= YW'(START_LANE);
            hold_q   <= '0;
            crash_q  <= 1'b0;
            finish_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            hold_q   <= hold_d;
            crash_q  <= crash_d;
            finish_q <= finish_d;
            fs_q     <= (state_d != ST_IDLE);
        end
    end

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        hold_d   = hold_q;
        crash_d  = 1'b0;
        finish_d = 1'b0;

        // Simultaneous up/down presses cancel each other.
        y_step = y_q;
        if (up_rise && !down_rise && (y_q != YW'(LANES - 1)))
            y_step = y_q + YW'(1);
        else if (down_rise && !up_rise && (y_q != '0))
            y_step = y_q - YW'(1);

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    x_d     = '0;
                    y_d     = YW'(START_LANE);
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                y_d = y_step;
                // Collision is judged on the lane the ship moves into this cycle.
                if (bus.forward_tick) begin
                    if (bus.obstacle_col[y_step]) begin
                        state_d = ST_CRASH;
                        crash_d = 1'b1;
                    end else if (x_q == XW'(TRACK_LEN - 2)) begin
                        x_d      = XW'(TRACK_LEN - 1);
                        state_d  = ST_FINISH;
                        finish_d = 1'b1;
                    end else begin
                        x_d = x_q + XW'(1);
                    end
                end
            end
            default: begin
                if (bus.forward_tick) begin
                    if (hold_q == HW'(HOLD_TICKS - 1)) begin
                        hold_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
        endcase
    end

    assign bus.ship_x       = x_q;
    assign bus.ship_y       = y_q;
    assign bus.game_state   = state_q;
    assign bus.first_start  = fs_q;
    assign bus.crash_pulse  = crash_q;
    assign bus.finish_pulse = finish_q;
endmodule
